// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM bundle for the RV32IM execute stage.
// master = pipeline/ctrl side driving EX, slave = ex_stage.
interface ex_stage_if #(parameter int PC_W = 12);
  logic [5:0]      stall;
  logic [5:0]      flash;
  logic [PC_W-1:0] pc_i;
  logic [6:0]      ex_opcode;
  logic [2:0]      ex_funct3;
  logic [6:0]      ex_funct7;
  logic [31:0]     ex_reg1;
  logic [31:0]     ex_reg2;
  logic [4:0]      ex_wd;
  logic            ex_wreg;
  logic [31:0]     imm_i;
  logic [4:0]      wd_o;
  logic            wreg_o;
  logic [31:0]     wdata_o;
  logic [31:0]     mem_addr_o;
  logic [31:0]     mem_wdata_o;
  logic [6:0]      mem_opcode_o;
  logic [2:0]      mem_funct3_o;
  logic            branch_o;
  logic [PC_W-1:0] branch_addr_o;
  logic            stallreq_o;

  modport master (
    output stall, flash, pc_i, ex_opcode, ex_funct3, ex_funct7, ex_reg1, ex_reg2,
           ex_wd, ex_wreg, imm_i,
    input  wd_o, wreg_o, wdata_o, mem_addr_o, mem_wdata_o, mem_opcode_o, mem_funct3_o,
           branch_o, branch_addr_o, stallreq_o
  );

  modport slave (
    input  stall, flash, pc_i, ex_opcode, ex_funct3, ex_funct7, ex_reg1, ex_reg2,
           ex_wd, ex_wreg, imm_i,
    output wd_o, wreg_o, wdata_o, mem_addr_o, mem_wdata_o, mem_opcode_o, mem_funct3_o,
           branch_o, branch_addr_o, stallreq_o
  );
endinterface

// File: rtl/ex_stage.sv
// RV32IM execute stage: combinational ALU/branch/MUL, iterative restoring divider.
//  state | meaning
//  IDLE  | no divide in flight; a new DIV/REM latches operands here
//  RUN   | one restoring step per cycle, cnt_q 0..31
//  DONE  | signed result presented; held while EX is stalled
module ex_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 12
) (
  input logic       clk,
  input logic       rst,
  ex_stage_if.slave io
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dsr_q, dsr_d;
  logic            neg_q_q, neg_q_d, neg_r_q, neg_r_d, sel_rem_q, sel_rem_d;

  logic              kill, is_m, div_op, mul_op;
  logic              div_signed, sgn1, sgn2;
  logic [XLEN-1:0]   abs1, abs2, q_res, r_res, div_res;
  logic [XLEN:0]     r_sh, diff;
  logic [XLEN-1:0]   op2, alu_res, jalr_sum;
  logic [4:0]        shamt;
  logic              taken;
  logic [PC_W-1:0]   pc_plus4, br_tgt, jalr_tgt;
  logic signed [XLEN:0]     mul_a, mul_b;
  logic signed [2*XLEN+1:0] mul_p;
  logic [XLEN-1:0]   mul_res;

  logic [XLEN-1:0] wdata_c, maddr_c;
  logic            wreg_c, branch_c, stallreq_c;
  logic [PC_W-1:0] tgt_c;

  assign kill   = io.flash[3];
  assign is_m   = (io.ex_opcode == OPC_OP) && (io.ex_funct7 == 7'b0000001);
  assign div_op = is_m & io.ex_funct3[2];
  assign mul_op = is_m & ~io.ex_funct3[2];

  // Divider works on magnitudes; signs are re-applied in DONE.
  assign div_signed = ~io.ex_funct3[0];
  assign sgn1       = div_signed & io.ex_reg1[XLEN-1];
  assign sgn2       = div_signed & io.ex_reg2[XLEN-1];
  assign abs1       = sgn1 ? -io.ex_reg1 : io.ex_reg1;
  assign abs2       = sgn2 ? -io.ex_reg2 : io.ex_reg2;
  assign r_sh       = {rem_q, quo_q[XLEN-1]};
  assign diff       = r_sh - {1'b0, dsr_q};
  assign q_res      = neg_q_q ? -quo_q : quo_q;
  assign r_res      = neg_r_q ? -rem_q : rem_q;
  assign div_res    = sel_rem_q ? r_res : q_res;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dsr_d     = dsr_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    sel_rem_d = sel_rem_q;
    case (state_q)
      S_IDLE: begin
        if (div_op && !kill) begin
          sel_rem_d = io.ex_funct3[1];
          neg_r_d   = sgn1;
          cnt_d     = 5'd0;
          dsr_d     = abs2;
          if (io.ex_reg2 == '0) begin
            // q = all ones unsigned, r = dividend: suppress quotient negation
            quo_d   = '1;
            rem_d   = abs1;
            neg_q_d = 1'b0;
            state_d = S_DONE;
          end else begin
            quo_d   = abs1;
            rem_d   = '0;
            neg_q_d = sgn1 ^ sgn2;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (!diff[XLEN]) begin
          rem_d = diff[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = r_sh[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_DONE;
      end
      S_DONE: begin
        if (!io.stall[3]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (kill) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dsr_q     <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      sel_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dsr_q     <= dsr_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      sel_rem_q <= sel_rem_d;
    end
  end

  assign op2   = (io.ex_opcode == OPC_OPIMM) ? io.imm_i : io.ex_reg2;
  assign shamt = op2[4:0];

  always_comb begin
    case (io.ex_funct3)
      3'b000:  alu_res = ((io.ex_opcode == OPC_OP) && io.ex_funct7[5]) ?
                         io.ex_reg1 - op2 : io.ex_reg1 + op2;
      3'b001:  alu_res = io.ex_reg1 << shamt;
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(io.ex_reg1) < $signed(op2)};
      3'b011:  alu_res = {{(XLEN-1){1'b0}}, io.ex_reg1 < op2};
      3'b100:  alu_res = io.ex_reg1 ^ op2;
      3'b101:  alu_res = io.ex_funct7[5] ? $unsigned($signed(io.ex_reg1) >>> shamt) :
                                           io.ex_reg1 >> shamt;
      3'b110:  alu_res = io.ex_reg1 | op2;
      default: alu_res = io.ex_reg1 & op2;
    endcase
  end

  always_comb begin
    case (io.ex_funct3)
      3'b000:  taken = io.ex_reg1 == io.ex_reg2;
      3'b001:  taken = io.ex_reg1 != io.ex_reg2;
      3'b100:  taken = $signed(io.ex_reg1) <  $signed(io.ex_reg2);
      3'b101:  taken = $signed(io.ex_reg1) >= $signed(io.ex_reg2);
      3'b110:  taken = io.ex_reg1 <  io.ex_reg2;
      3'b111:  taken = io.ex_reg1 >= io.ex_reg2;
      default: taken = 1'b0;
    endcase
  end

  // 33x33 signed product covers MUL, MULH, MULHSU and MULHU.
  assign mul_a   = {(io.ex_funct3[1:0] != 2'b11) & io.ex_reg1[XLEN-1], io.ex_reg1};
  assign mul_b   = {(io.ex_funct3[1:0] == 2'b01) & io.ex_reg2[XLEN-1], io.ex_reg2};
  assign mul_p   = (2*XLEN+2)'(mul_a) * (2*XLEN+2)'(mul_b);
  assign mul_res = (io.ex_funct3[1:0] == 2'b00) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];

  assign pc_plus4 = io.pc_i + PC_W'(4);
  assign br_tgt   = io.pc_i + io.imm_i[PC_W-1:0];
  assign jalr_sum = io.ex_reg1 + io.imm_i;
  assign jalr_tgt = {jalr_sum[PC_W-1:1], 1'b0};

  always_comb begin
    wdata_c  = '0;
    wreg_c   = 1'b0;
    branch_c = 1'b0;
    tgt_c    = br_tgt;
    maddr_c  = '0;
    case (io.ex_opcode)
      OPC_OP: begin
        wreg_c  = io.ex_wreg;
        wdata_c = mul_op ? mul_res : alu_res;
      end
      OPC_OPIMM: begin
        wreg_c  = io.ex_wreg;
        wdata_c = alu_res;
      end
      OPC_LUI: begin
        wreg_c  = io.ex_wreg;
        wdata_c = io.imm_i;
      end
      OPC_AUIPC: begin
        wreg_c  = io.ex_wreg;
        wdata_c = {{(XLEN-PC_W){1'b0}}, io.pc_i} + io.imm_i;
      end
      OPC_JAL, OPC_JALR: begin
        wreg_c   = io.ex_wreg;
        wdata_c  = {{(XLEN-PC_W){1'b0}}, pc_plus4};
        branch_c = 1'b1;
        tgt_c    = (io.ex_opcode == OPC_JALR) ? jalr_tgt : br_tgt;
      end
      OPC_BRANCH: branch_c = taken;
      OPC_LOAD: begin
        wreg_c  = io.ex_wreg;
        maddr_c = jalr_sum;
      end
      OPC_STORE: maddr_c = jalr_sum;
      default: ;
    endcase
    if (state_q == S_DONE) begin
      wdata_c  = div_res;
      wreg_c   = io.ex_wreg & ~kill;
      branch_c = 1'b0;
    end else if ((state_q == S_RUN) || div_op) begin
      wdata_c  = '0;
      wreg_c   = 1'b0;
      branch_c = 1'b0;
    end
  end

  assign stallreq_c = !kill && (((state_q == S_IDLE) && div_op) || (state_q == S_RUN));

  always_comb begin
    if (rst) begin
      io.wd_o          = io.ex_wd;
      io.wreg_o        = wreg_c;
      io.wdata_o       = wdata_c;
      io.mem_addr_o    = maddr_c;
      io.mem_wdata_o   = io.ex_reg2;
      io.mem_opcode_o  = io.ex_opcode;
      io.mem_funct3_o  = io.ex_funct3;
      io.branch_o      = branch_c;
      io.branch_addr_o = tgt_c;
      io.stallreq_o    = stallreq_c;
    end else begin
      io.wd_o          = '0;
      io.wreg_o        = 1'b0;
      io.wdata_o       = '0;
      io.mem_addr_o    = '0;
      io.mem_wdata_o   = '0;
      io.mem_opcode_o  = '0;
      io.mem_funct3_o  = '0;
      io.branch_o      = 1'b0;
      io.branch_addr_o = '0;
      io.stallreq_o    = 1'b0;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{io.stall[5:4], io.stall[2:0], io.flash[5:4], io.flash[2:0],
                       mul_p[2*XLEN+1:2*XLEN], jalr_sum[XLEN-1:PC_W], jalr_sum[0],
                       r_sh[XLEN]};

endmodule
